// File: rtl/wall_pkg.sv
// Shared types and colour constants for the wall sequencer.
package wall_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StApproach = 2'd1,
      StCheck    = 2'd2,
      StResult   = 2'd3
   } state_e;

   localparam logic [15:0] DEFAULT_WALL_COLOR = 16'h001F;
   localparam logic [15:0] PASS_COLOR         = 16'h07E0;
   localparam logic [15:0] FAIL_COLOR         = 16'hF800;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/overlap_counter.sv
// 16-bit saturating counter of wall/player overlap pixels; clear wins over enable.
module overlap_counter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        enable_i,
   output logic [15:0] count_o
);

   logic [15:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         count_q <= '0;
      end else if (enable_i && (count_q != 16'hFFFF)) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/wall_sequencer.sv
// Wall approach / collision-check / result sequencer for the hole-in-the-wall game.
module wall_sequencer
   import wall_pkg::*;
#(
   parameter int unsigned ACTIVE_H_PIXELS = 1280,
   parameter int unsigned ACTIVE_LINES    = 720,
   parameter logic [7:0]  START_DEPTH     = 8'd255,
   parameter int unsigned FRAMES_PER_STEP = 2,
   parameter logic [7:0]  DEPTH_STEP      = 8'd1,
   parameter logic [15:0] HIT_THRESHOLD   = 16'd64,
   parameter int unsigned RESULT_FRAMES   = 60,
   parameter logic [15:0] WALL_COLOR      = DEFAULT_WALL_COLOR
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_in,
   input  logic        new_frame_in,
   input  logic [10:0] h_count_in,
   input  logic [9:0]  v_count_in,
   input  logic        is_wall_in,
   input  logic        is_player_in,
   input  logic [7:0]  player_depth_in,
   output logic [7:0]  wall_depth_out,
   output logic [15:0] wall_color_out,
   output logic        wall_active_out,
   output logic        check_done_out,
   output logic        pass_out,
   output logic [7:0]  score_out,
   output logic [1:0]  state_out
);

   localparam logic [10:0] HLimit     = 11'(ACTIVE_H_PIXELS);
   localparam logic [9:0]  VLimit     = 10'(ACTIVE_LINES);
   localparam logic [15:0] StepLast   = 16'(FRAMES_PER_STEP - 1);
   localparam logic [15:0] ResultLast = 16'(RESULT_FRAMES - 1);

   state_e      state_q;
   logic [7:0]  depth_q;
   logic [15:0] color_q;
   logic        active_q;
   logic        done_q;
   logic        pass_q;
   logic [7:0]  score_q;
   logic [15:0] frame_cnt_q;
   logic        armed_q;

   logic [15:0] overlap_cnt;
   logic        in_active;
   logic        cnt_en;
   logic        cnt_clear;
   logic        depth_reach;
   logic        pass_now;

   assign in_active = (h_count_in < HLimit) && (v_count_in < VLimit);
   assign cnt_en    = (state_q == StCheck) && armed_q && in_active && is_wall_in && is_player_in;
   assign cnt_clear = (state_q == StCheck) && new_frame_in && !armed_q;
   assign pass_now  = overlap_cnt < HIT_THRESHOLD;
   // 9-bit compare so player depths near 255 cannot wrap past the wall.
   assign depth_reach = {1'b0, depth_q} <= ({1'b0, player_depth_in} + {1'b0, DEPTH_STEP});

   overlap_counter u_overlap_counter (
      .clk_i    (clk_in),
      .rst_i    (rst_in),
      .clear_i  (cnt_clear),
      .enable_i (cnt_en),
      .count_o  (overlap_cnt)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= StIdle;
         depth_q     <= START_DEPTH;
         color_q     <= WALL_COLOR;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         score_q     <= 8'd0;
         frame_cnt_q <= 16'd0;
         armed_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_in) begin
                  state_q     <= StApproach;
                  depth_q     <= START_DEPTH;
                  color_q     <= WALL_COLOR;
                  active_q    <= 1'b1;
                  pass_q      <= 1'b0;
                  score_q     <= 8'd0;
                  frame_cnt_q <= 16'd0;
               end
            end
            StApproach: begin
               if (new_frame_in) begin
                  if (frame_cnt_q == StepLast) begin
                     frame_cnt_q <= 16'd0;
                     if (depth_reach) begin
                        depth_q <= player_depth_in;
                        state_q <= StCheck;
                        armed_q <= 1'b0;
                     end else begin
                        depth_q <= depth_q - DEPTH_STEP;
                     end
                  end else begin
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                  end
               end
            end
            StCheck: begin
               // First frame pulse arms the count, the second closes it.
               if (new_frame_in) begin
                  if (!armed_q) begin
                     armed_q <= 1'b1;
                  end else begin
                     armed_q     <= 1'b0;
                     pass_q      <= pass_now;
                     done_q      <= 1'b1;
                     color_q     <= pass_now ? PASS_COLOR : FAIL_COLOR;
                     state_q     <= StResult;
                     frame_cnt_q <= 16'd0;
                     if (pass_now) begin
                        score_q <= sat_inc8(score_q);
                     end
                  end
               end
            end
            StResult: begin
               if (new_frame_in) begin
                  if (frame_cnt_q == ResultLast) begin
                     frame_cnt_q <= 16'd0;
                     depth_q     <= START_DEPTH;
                     color_q     <= WALL_COLOR;
                     if (pass_q) begin
                        state_q <= StApproach;
                     end else begin
                        state_q  <= StIdle;
                        active_q <= 1'b0;
                     end
                  end else begin
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                  end
               end
            end
         endcase
      end
   end

   assign wall_depth_out  = depth_q;
   assign wall_color_out  = color_q;
   assign wall_active_out = active_q;
   assign check_done_out  = done_q;
   assign pass_out        = pass_q;
   assign score_out       = score_q;
   assign state_out       = state_q;

endmodule
